// File: rtl/vga_pkg.sv
// Shared VGA timing package.
// Holds the default 640x480@60Hz timing constants, the derived line/frame
// totals, the default sync window positions and the content window height
// that the frame buffer also sizes its address space from.
package vga_pkg;

    localparam int VGA_H_VISIBLE    = 640;
    localparam int VGA_H_FRONT      = 16;
    localparam int VGA_H_SYNC       = 96;
    localparam int VGA_H_BACK       = 48;
    localparam int VGA_V_VISIBLE    = 480;
    localparam int VGA_V_FRONT      = 10;
    localparam int VGA_V_SYNC       = 2;
    localparam int VGA_V_BACK       = 33;
    localparam int VGA_V_BORDER     = 40;
    localparam int VGA_SYNC_DELAY   = 2;
    localparam int VGA_BLINK_FRAMES = 16;

    // Counter and coordinate widths; 10 bits covers both 800 and 525.
    localparam int CNT_W = 10;
    localparam int ROW_W = 10;
    localparam int COL_W = 10;

    function automatic int span_total(input int visible, input int front,
                                      input int sync_w, input int back);
        return visible + front + sync_w + back;
    endfunction

    localparam int VGA_H_TOTAL = span_total(VGA_H_VISIBLE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
    localparam int VGA_V_TOTAL = span_total(VGA_V_VISIBLE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);

    // Inclusive sync windows in counter coordinates (656..751, 490..491).
    localparam int VGA_HSYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int VGA_HSYNC_END   = VGA_HSYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_VSYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int VGA_VSYNC_END   = VGA_VSYNC_START + VGA_V_SYNC - 1;

    localparam int CONTENT_LINES = VGA_V_VISIBLE - 2 * VGA_V_BORDER;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the frame buffer / DAC path.
//   master: driven by the timing generator
//   slave : consumed by the frame buffer, DAC and CPU status register
// Signals: row, col, is_blank, is_border, hsync, vsync, vretrace,
//          display_disable, frame_start, cursor_blink.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             is_blank;
    logic             is_border;
    logic             hsync;
    logic             vsync;
    logic             vretrace;
    logic             display_disable;
    logic             frame_start;
    logic             cursor_blink;

    modport master (
        output row, col, is_blank, is_border, hsync, vsync,
               vretrace, display_disable, frame_start, cursor_blink
    );

    modport slave (
        input  row, col, is_blank, is_border, hsync, vsync,
               vretrace, display_disable, frame_start, cursor_blink
    );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-length shift line with a per-bit reset value.
// Ports:
//   clk     - clock
//   reset_n - asynchronous active-low reset, loads RST_VAL into every stage
//   din     - input word
//   dout    - din delayed by DEPTH cycles (combinational pass-through if DEPTH=0)
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        // Clock and reset are not needed when the line has no stages.
        logic unused_ctrl;
        assign unused_ctrl = clk ^ reset_n;
        assign dout = din;
    end else begin : g_line
        logic [WIDTH-1:0] taps [DEPTH];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) taps[i] <= RST_VAL;
            end else begin
                taps[0] <= din;
                for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
            end
        end

        assign dout = taps[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator feeding the frame buffer and the DAC.
// Runs free-running h/v counters, decodes visible/border/content regions,
// registers all outputs one cycle after the counter state they describe, and
// delays hsync/vsync by SYNC_DELAY more cycles to line up with the pixel path.
// Ports:
//   clk     - pixel clock
//   reset_n - asynchronous active-low reset
//   vid     - master side of vga_timing_gen_if (row, col, is_blank, is_border,
//             hsync, vsync, vretrace, display_disable, frame_start, cursor_blink)
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE    = VGA_H_VISIBLE,
    parameter int H_FRONT      = VGA_H_FRONT,
    parameter int H_SYNC       = VGA_H_SYNC,
    parameter int H_BACK       = VGA_H_BACK,
    parameter int V_VISIBLE    = VGA_V_VISIBLE,
    parameter int V_FRONT      = VGA_V_FRONT,
    parameter int V_SYNC       = VGA_V_SYNC,
    parameter int V_BACK       = VGA_V_BACK,
    parameter int V_BORDER     = VGA_V_BORDER,
    parameter int SYNC_DELAY   = VGA_SYNC_DELAY,
    parameter int BLINK_FRAMES = VGA_BLINK_FRAMES
) (
    input  logic             clk,
    input  logic             reset_n,
    vga_timing_gen_if.master vid
);

    localparam int H_TOTAL = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int FC_W    = $clog2(BLINK_FRAMES + 1);

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS     = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS     = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] V_BRD     = CNT_W'(V_BORDER);
    localparam logic [CNT_W-1:0] V_BRD_END = CNT_W'(V_VISIBLE - V_BORDER);
    localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(BLINK_FRAMES - 1);

    if (2 * V_BORDER >= V_VISIBLE || V_VISIBLE - 2 * V_BORDER > 1024) begin : g_bad_border
        $error("vga_timing_gen: V_BORDER leaves no valid content window");
    end
    if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_bad_total
        $error("vga_timing_gen: line or frame total exceeds counter range");
    end

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + CNT_W'(1);
        end else begin
            h_count <= h_count + CNT_W'(1);
        end
    end

    // Stage p0: region decode straight off the counters.
    logic             visible_p0;
    logic             border_line_p0;
    logic             content_p0;
    logic [ROW_W-1:0] row_p0;
    logic [COL_W-1:0] col_p0;
    logic             hs_p0;
    logic             vs_p0;

    always_comb begin
        visible_p0     = (h_count < H_VIS) && (v_count < V_VIS);
        border_line_p0 = (v_count < V_BRD) || (v_count >= V_BRD_END);
        content_p0     = visible_p0 && !border_line_p0;
        // Gated by content, so v_count >= V_BORDER and this cannot underflow.
        row_p0         = content_p0 ? (v_count - V_BRD) : '0;
        col_p0         = visible_p0 ? h_count : '0;
        hs_p0          = !((h_count >= HS_START) && (h_count <= HS_END));
        vs_p0          = !((v_count >= VS_START) && (v_count <= VS_END));
    end

    // Stage p1: registered outputs, one cycle behind the counters.
    logic [ROW_W-1:0] row_p1;
    logic [COL_W-1:0] col_p1;
    logic             blank_p1;
    logic             border_p1;
    logic             hs_p1;
    logic             vs_p1;
    logic             vretrace_p1;
    logic             disable_p1;
    logic             frame_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_p1      <= '0;
            col_p1      <= '0;
            blank_p1    <= 1'b1;
            border_p1   <= 1'b0;
            hs_p1       <= 1'b1;
            vs_p1       <= 1'b1;
            vretrace_p1 <= 1'b0;
            disable_p1  <= 1'b1;
            frame_p1    <= 1'b0;
        end else begin
            row_p1      <= row_p0;
            col_p1      <= col_p0;
            blank_p1    <= !visible_p0;
            border_p1   <= visible_p0 && border_line_p0;
            hs_p1       <= hs_p0;
            vs_p1       <= vs_p0;
            vretrace_p1 <= (v_count >= V_VIS);
            disable_p1  <= !content_p0;
            frame_p1    <= (h_count == '0) && (v_count == '0);
        end
    end

    // Cursor blink: counts emitted frame_start pulses.
    logic [FC_W-1:0] frame_cnt;
    logic            blink;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            blink     <= 1'b0;
        end else if (frame_p1) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt <= '0;
                blink     <= ~blink;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end

    // Stage p2: sync alignment with the frame buffer RAM and glyph stage.
    logic [1:0] sync_p2;

    vga_delay_line #(
        .WIDTH   (2),
        .DEPTH   (SYNC_DELAY),
        .RST_VAL (2'b11)
    ) u_sync_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({hs_p1, vs_p1}),
        .dout    (sync_p2)
    );

    assign vid.row             = row_p1;
    assign vid.col             = col_p1;
    assign vid.is_blank        = blank_p1;
    assign vid.is_border       = border_p1;
    assign vid.hsync           = sync_p2[1];
    assign vid.vsync           = sync_p2[0];
    assign vid.vretrace        = vretrace_p1;
    assign vid.display_disable = disable_p1;
    assign vid.frame_start     = frame_p1;
    assign vid.cursor_blink    = blink;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a scaled-down raster so that full
// frames and the 33-frame blink sequence stay short:
//   H: 16 visible, 2 front, 3 sync, 3 back  -> 24 per line, hsync low h=18..20
//   V: 12 visible, 1 front, 2 sync, 2 back  -> 17 lines, vsync low v=13..14
//   2 border lines -> content v=2..9, row 0..7; 408 cycles per frame.
// t counts negedges after the first post-reset posedge; the outputs seen at
// t describe counter state (h,v) with t = v*24 + h within a frame.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int FRAME = 408;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    int   t = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   fall0 = -1;
    int   fall1 = -1;
    int   hs_low = 0;
    int   vs_low = 0;
    int   vr_hi = 0;
    int   fs_cnt = 0;
    int   pulses = 0;
    logic prev_hs = 1'b1;

    vga_timing_gen_if vif ();
    vga_timing_gen_if vif0 ();

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .V_BORDER(2), .SYNC_DELAY(2), .BLINK_FRAMES(16)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .vid     (vif)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .V_BORDER(2), .SYNC_DELAY(0), .BLINK_FRAMES(16)
    ) u_dut_nodelay (
        .clk     (clk),
        .reset_n (reset_n),
        .vid     (vif0)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        t++;
    endtask

    task automatic goto(input int target);
        while (t < target) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        check_val("rst_row",      32'(vif.row), 0);
        check_val("rst_col",      32'(vif.col), 0);
        check_val("rst_blank",    32'(vif.is_blank), 1);
        check_val("rst_border",   32'(vif.is_border), 0);
        check_val("rst_hsync",    32'(vif.hsync), 1);
        check_val("rst_vsync",    32'(vif.vsync), 1);
        check_val("rst_vretrace", 32'(vif.vretrace), 0);
        check_val("rst_disable",  32'(vif.display_disable), 1);
        check_val("rst_fstart",   32'(vif.frame_start), 0);
        check_val("rst_blink",    32'(vif.cursor_blink), 0);
        reset_n = 1'b1;
        @(negedge clk);
        t = 0;

        // First output cycle: counter (0,0)
        check_val("t0_fstart",  32'(vif.frame_start), 1);
        check_val("t0_col",     32'(vif.col), 0);
        check_val("t0_blank",   32'(vif.is_blank), 0);
        check_val("t0_border",  32'(vif.is_border), 1);
        check_val("t0_hsync",   32'(vif.hsync), 1);
        check_val("t0_disable", 32'(vif.display_disable), 1);
        goto(1);
        check_val("t1_fstart",  32'(vif.frame_start), 0);
        check_val("t1_col",     32'(vif.col), 1);

        // hsync edges: undelayed instance first, then SYNC_DELAY=2
        goto(17);
        check_val("nd_hs_t17", 32'(vif0.hsync), 1);
        goto(18);
        check_val("nd_hs_t18", 32'(vif0.hsync), 0);
        check_val("hs_t18",    32'(vif.hsync), 1);
        goto(19);
        check_val("hs_t19",    32'(vif.hsync), 1);
        goto(20);
        check_val("hs_t20",    32'(vif.hsync), 0);
        check_val("nd_hs_t20", 32'(vif0.hsync), 0);
        goto(21);
        check_val("nd_hs_t21", 32'(vif0.hsync), 1);
        goto(22);
        check_val("hs_t22",    32'(vif.hsync), 0);
        goto(23);
        check_val("hs_t23",    32'(vif.hsync), 1);

        // Content window boundaries
        goto(29);   // v=1 h=5, last top border line
        check_val("v1_border",  32'(vif.is_border), 1);
        check_val("v1_row",     32'(vif.row), 0);
        check_val("v1_disable", 32'(vif.display_disable), 1);
        goto(53);   // v=2 h=5, first content line
        check_val("v2_row",     32'(vif.row), 0);
        check_val("v2_border",  32'(vif.is_border), 0);
        check_val("v2_disable", 32'(vif.display_disable), 0);
        check_val("v2_col",     32'(vif.col), 5);
        goto(231);  // v=9 h=15, last content pixel
        check_val("v9_row",     32'(vif.row), 7);
        check_val("v9_col",     32'(vif.col), 15);
        goto(240);  // v=10 h=0, first bottom border line
        check_val("v10_border", 32'(vif.is_border), 1);
        check_val("v10_row",    32'(vif.row), 0);
        goto(256);  // v=10 h=16, first blank pixel
        check_val("h16_col",    32'(vif.col), 0);
        check_val("h16_blank",  32'(vif.is_blank), 1);
        check_val("h16_border", 32'(vif.is_border), 0);
        goto(267);  // v=11 h=3
        check_val("v11_border", 32'(vif.is_border), 1);
        goto(288);  // v=12 h=0, vertical blanking
        check_val("v12_blank",    32'(vif.is_blank), 1);
        check_val("v12_vretrace", 32'(vif.vretrace), 1);
        check_val("v12_border",   32'(vif.is_border), 0);
        check_val("v12_disable",  32'(vif.display_disable), 1);
        goto(313);
        check_val("vs_t313", 32'(vif.vsync), 1);
        goto(314);
        check_val("vs_t314", 32'(vif.vsync), 0);
        goto(361);
        check_val("vs_t361", 32'(vif.vsync), 0);
        goto(362);
        check_val("vs_t362", 32'(vif.vsync), 1);
        goto(407);
        check_val("t407_vretrace", 32'(vif.vretrace), 1);
        check_val("t407_fstart",   32'(vif.frame_start), 0);
        goto(408);
        check_val("f2_fstart",   32'(vif.frame_start), 1);
        check_val("f2_vretrace", 32'(vif.vretrace), 0);
        check_val("f2_border",   32'(vif.is_border), 1);

        // Whole-frame measurement over t=408..815
        prev_hs = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            if (prev_hs && !vif.hsync) begin
                if (fall0 < 0) fall0 = t;
                else if (fall1 < 0) fall1 = t;
            end
            prev_hs = vif.hsync;
            if (!vif.hsync) hs_low++;
            if (!vif.vsync) vs_low++;
            if (vif.vretrace) vr_hi++;
            if (vif.frame_start) fs_cnt++;
            step();
        end
        check_val("hs_first_fall", 32'(fall0 - FRAME), 20);
        check_val("hs_period",     32'(fall1 - fall0), 24);
        check_val("hs_low_frame",  32'(hs_low), 51);
        check_val("vs_low_frame",  32'(vs_low), 48);
        check_val("vretrace_frame",32'(vr_hi), 120);
        check_val("fstart_frame",  32'(fs_cnt), 1);

        // Blink over 33 frames; two pulses already seen at t=0 and t=408
        pulses = 2;
        while (pulses < 33 && t < 33 * FRAME) begin
            if (vif.frame_start) begin
                pulses++;
                if (pulses == 16) check_val("blink_p16", 32'(vif.cursor_blink), 0);
                if (pulses == 17) check_val("blink_p17", 32'(vif.cursor_blink), 1);
                if (pulses == 32) check_val("blink_p32", 32'(vif.cursor_blink), 1);
                if (pulses == 33) check_val("blink_p33", 32'(vif.cursor_blink), 0);
            end
            if (pulses < 33) step();
        end
        check_val("fstart_count", 32'(pulses), 33);
        check_val("p33_time",     32'(t), 32 * FRAME);

        // Mid-frame reset at v=5 h=7
        goto(32 * FRAME + 5 * 24 + 7);
        check_val("pre_rst_row", 32'(vif.row), 3);
        check_val("pre_rst_col", 32'(vif.col), 7);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_row",     32'(vif.row), 0);
        check_val("arst_col",     32'(vif.col), 0);
        check_val("arst_blank",   32'(vif.is_blank), 1);
        check_val("arst_hsync",   32'(vif.hsync), 1);
        check_val("arst_vsync",   32'(vif.vsync), 1);
        check_val("arst_disable", 32'(vif.display_disable), 1);
        check_val("arst_fstart",  32'(vif.frame_start), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        t = 0;
        check_val("rr_fstart", 32'(vif.frame_start), 1);
        hs_low = 0;
        for (int i = 0; i < 20; i++) begin
            if (!vif.hsync) hs_low++;
            if (t == 7) check_val("rr_col7", 32'(vif.col), 7);
            step();
        end
        check_val("rr_no_short_hs", 32'(hs_low), 0);
        check_val("rr_hs_t20",      32'(vif.hsync), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
